// File: rtl/rand_vec_sampler_pkg.sv
// -----------------------------------------------------------------------------
// rand_vec_sampler_pkg
// Shared types and constants for the unit-ball rejection sampler.
//   fixed_real : Q32.32 signed scalar
//   vector     : three fixed_real components, [0]=x, [1]=y, [2]=z
//   comp_t     : 33-bit signed component taken from the random word, c/2^32
//   sq_t       : 65-bit unsigned square, 2^64 == 1.0
//   sum_t      : 67-bit unsigned sum of three squares
//   state_t    : sampler FSM states
// -----------------------------------------------------------------------------
package rand_vec_sampler_pkg;

   typedef logic signed [63:0] fixed_real;
   typedef fixed_real [2:0]    vector;

   localparam int        FIXED_FRAC = 32;
   localparam fixed_real FIXED_ONE  = 64'h0000_0001_0000_0000;
   localparam fixed_real FALLBACK_Z = 64'h0000_0000_8000_0000;

   typedef logic signed [FIXED_FRAC:0]     comp_t;
   typedef logic        [2*FIXED_FRAC:0]   sq_t;
   typedef logic        [2*FIXED_FRAC+2:0] sum_t;

   // 1.0 expressed on the scale of the squared sum (2^64).
   localparam sum_t SUM_ONE = sum_t'(FIXED_ONE) << FIXED_FRAC;

   typedef enum logic [2:0] {
      S_X   = 3'd0,
      S_Y   = 3'd1,
      S_Z   = 3'd2,
      S_SQ  = 3'd3,
      S_CMP = 3'd4,
      S_OUT = 3'd5
   } state_t;

   // Sign-extend a 33-bit component into a Q32.32 word.
   function automatic fixed_real comp_to_fixed(input comp_t c);
      return {{(63 - FIXED_FRAC){c[FIXED_FRAC]}}, c};
   endfunction

endpackage

// File: rtl/rand_vec_sampler_if.sv
// -----------------------------------------------------------------------------
// rand_vec_sampler_if
// Output stream of the sampler.
//   vec       : accepted (or fallback) point
//   out_valid : vec holds a sample
//   out_ready : consumer takes vec this cycle
//   fallback  : 1 = vec is the fallback point after too many rejections
// Modports: master (sampler side), slave (consumer side).
// -----------------------------------------------------------------------------
interface rand_vec_sampler_if;
   import rand_vec_sampler_pkg::*;

   vector vec;
   logic  out_valid;
   logic  out_ready;
   logic  fallback;

   modport master (output vec, output out_valid, output fallback, input out_ready);
   modport slave  (input vec, input out_valid, input fallback, output out_ready);

endinterface

// File: rtl/rand_vec_sampler_rand_sq.sv
// -----------------------------------------------------------------------------
// rand_sq
// Registered squarer: 33-bit signed input, 65-bit unsigned output.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_en           : load the square of i_a on this edge
//   i_a            : signed component
//   o_sq           : registered i_a * i_a
// -----------------------------------------------------------------------------
module rand_sq
   import rand_vec_sampler_pkg::*;
(
   input  logic  i_clk,
   input  logic  i_rst_n,
   input  logic  i_en,
   input  comp_t i_a,
   output sq_t   o_sq
);

   logic signed [2*FIXED_FRAC+1:0] w_a_ext;
   logic signed [2*FIXED_FRAC+1:0] w_prod;
   logic                           w_unused_sign;
   sq_t                            r_sq;

   assign w_a_ext = (2*FIXED_FRAC+2)'(i_a);
   assign w_prod  = w_a_ext * w_a_ext;
   // A square is never negative, so the top bit carries no information.
   assign w_unused_sign = w_prod[2*FIXED_FRAC+1];

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)  r_sq <= '0;
      else if (i_en) r_sq <= w_prod[2*FIXED_FRAC:0];
   end

   assign o_sq = r_sq;

endmodule

// File: rtl/rand_vec_sampler.sv
// -----------------------------------------------------------------------------
// rand_vec_sampler
// Rejection sampler producing points uniformly distributed in the unit ball.
// Three successive random words give x, y, z (low 33 bits, signed, /2^32);
// the triple is accepted when x^2+y^2+z^2 < 1.0. After MAX_TRIES consecutive
// rejections the fixed point (0, 0, 0.5) is emitted with fallback=1.
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_rand_in        : free-running random word, one per cycle, no handshake
//   o_vec_if         : output stream (vec/out_valid/out_ready/fallback)
//   o_reject_count   : saturating rejection counter (RAND_SAMPLER_STATS_EN)
// Optional feature macro: RAND_SAMPLER_STATS_EN
// -----------------------------------------------------------------------------
module rand_vec_sampler
   import rand_vec_sampler_pkg::*;
#(
   parameter int unsigned MAX_TRIES = 16
)(
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  fixed_real                 i_rand_in,
   rand_vec_sampler_if.master        o_vec_if
`ifdef RAND_SAMPLER_STATS_EN
   ,
   output logic [31:0]               o_reject_count
`endif
);

   localparam logic [7:0] LAST_TRY = 8'(MAX_TRIES - 1);

   state_t     r_state;
   state_t     w_next_state;
   comp_t      r_x, r_y, r_z;
   logic [7:0] r_tries;
   vector      r_vec;
   logic       r_fallback;

   comp_t      w_comp;
   logic       w_unused_rand;
   sq_t        w_sq_x, w_sq_y, w_sq_z;
   sum_t       w_sum;
   logic       w_accept;
   logic       w_last_try;
   logic       w_sq_en;

   assign w_comp        = i_rand_in[FIXED_FRAC:0];
   assign w_unused_rand = ^i_rand_in[63:FIXED_FRAC+1];

   assign w_sq_en = (r_state == S_SQ);

   rand_sq u_sq_x (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(w_sq_en), .i_a(r_x), .o_sq(w_sq_x));
   rand_sq u_sq_y (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(w_sq_en), .i_a(r_y), .o_sq(w_sq_y));
   rand_sq u_sq_z (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(w_sq_en), .i_a(r_z), .o_sq(w_sq_z));

   // -1.0 squares to exactly 2^64, so it can never pass the strict compare.
   assign w_sum      = sum_t'(w_sq_x) + sum_t'(w_sq_y) + sum_t'(w_sq_z);
   assign w_accept   = (w_sum < SUM_ONE);
   assign w_last_try = (r_tries == LAST_TRY);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_X;
      else          r_state <= w_next_state;
   end

   // NOTE: the default assignment at the top keeps this block free of
   // inferred latches when a branch does not mention the signal.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_X:     w_next_state = S_Y;
         S_Y:     w_next_state = S_Z;
         S_Z:     w_next_state = S_SQ;
         S_SQ:    w_next_state = S_CMP;
         S_CMP:   w_next_state = (w_accept || w_last_try) ? S_OUT : S_X;
         S_OUT:   if (o_vec_if.out_ready) w_next_state = S_X;
         default: w_next_state = S_X;
      endcase
   end

   // NOTE: the datapath registers are plain flops, not a memory array, so
   // they take the asynchronous reset like every other piece of state.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_x        <= '0;
         r_y        <= '0;
         r_z        <= '0;
         r_tries    <= '0;
         r_vec      <= '0;
         r_fallback <= 1'b0;
      end else begin
         case (r_state)
            S_X: r_x <= w_comp;
            S_Y: r_y <= w_comp;
            S_Z: r_z <= w_comp;
            S_CMP: begin
               if (w_accept) begin
                  r_vec[0]   <= comp_to_fixed(r_x);
                  r_vec[1]   <= comp_to_fixed(r_y);
                  r_vec[2]   <= comp_to_fixed(r_z);
                  r_fallback <= 1'b0;
                  r_tries    <= '0;
               end else if (w_last_try) begin
                  r_vec[0]   <= '0;
                  r_vec[1]   <= '0;
                  r_vec[2]   <= FALLBACK_Z;
                  r_fallback <= 1'b1;
                  r_tries    <= '0;
               end else begin
                  r_tries    <= r_tries + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef RAND_SAMPLER_STATS_EN
   logic [31:0] r_reject_count;

   // Counts every rejection, including the one that triggers the fallback.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_reject_count <= '0;
      else if (r_state == S_CMP && !w_accept && r_reject_count != 32'hFFFF_FFFF)
         r_reject_count <= r_reject_count + 32'd1;
   end

   assign o_reject_count = r_reject_count;
`endif

   // out_valid decodes registered state only; it never sees out_ready.
   assign o_vec_if.out_valid = (r_state == S_OUT);
   assign o_vec_if.vec       = r_vec;
   assign o_vec_if.fallback  = r_fallback;

endmodule

// File: doc/rand_vec_sampler.md
# rand_vec_sampler

Consumes the free-running 64-bit random word stream from the random-number LUT generator and turns it into random points uniformly distributed inside the unit ball. It uses rejection sampling. Each accepted point is presented as a `vector` of Q32.32 `fixed_real` components on a valid/ready output. The ray-tracing core uses it for diffuse-bounce direction generation.

## Interface
- MAX_TRIES, 16: consecutive rejections allowed before a fallback vector is emitted (1..255).
- Clk  in  1  system clock, all state on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- rand_in  in  64 (`fixed_real`)  random word. A new value is expected every cycle; there is no handshake on this side.
- vec  out  192 (`vector`)  accepted point, components [0]=x, [1]=y, [2]=z, Q32.32.
- out_valid  out  1  vec holds an accepted or fallback sample.
- out_ready  in  1  consumer accepts vec this cycle.
- fallback  out  1  qualifies vec: 1 = fallback vector produced after MAX_TRIES rejections.
- reject_count  out  32  present only with RAND_SAMPLER_STATS_EN.

## Operation
- Component extraction: c = rand_in[32:0] as a 33-bit signed value c/2^32, range [-1.0, 1.0). rand_in[63:33] is ignored.
- FSM states: S_X, S_Y, S_Z, S_SQ, S_CMP, S_OUT.
- S_X, S_Y, S_Z: capture x, y, z from rand_in on successive cycles.
- S_SQ: register the three squares.
  - Each square is 33x33 signed, giving a 65-bit unsigned result; 2^64 represents 1.0.
- S_CMP: form the 67-bit sum s = x² + y² + z².
  - Accept iff s < 2^64 (strict). On accept: load vec with each c sign-extended to 64 bits, fallback=0, tries=0, go to S_OUT.
  - Reject with tries < MAX_TRIES-1: tries+1, go to S_X.
  - Reject with tries = MAX_TRIES-1: load vec = (0, 0, 64'h0000_0000_8000_0000), i.e. z = 0.5; set fallback=1, tries=0, go to S_OUT.
- S_OUT: out_valid=1. vec and fallback are held stable while out_ready=0. On out_valid & out_ready, go to S_X.
- rand_in is ignored in S_SQ, S_CMP and S_OUT.
- -1.0 (33'h1_0000_0000) squares to exactly 2^64 and is always rejected.

## Timing
- Reset values: state=S_X, out_valid=0, vec=0, fallback=0, tries=0, reject_count=0.
- Reset takes effect asynchronously in any state. An in-flight sample is discarded, and the first capture happens on the first rising edge after Reset deasserts.
- Latency: x is captured at edge 1, y at edge 2, z at edge 3, squares at edge 4, compare at edge 5. out_valid is high after edge 5 when the first triple is accepted.
- Each rejection adds 5 cycles.
- With out_ready held high, the minimum spacing between accepted samples is 6 cycles.
- out_valid falls on the edge that completes the handshake. The next sample cannot appear sooner than 5 cycles later.
- out_valid never depends combinationally on out_ready.

## Configuration
- RAND_SAMPLER_STATS_EN defined: the reject_count port and register exist.
  - Increments by 1 on every S_CMP rejection, including the rejection that triggers the fallback.
  - Saturates at 32'hFFFF_FFFF and clears only on reset.
- RAND_SAMPLER_STATS_EN undefined: the port and register are absent. Sampling behaviour is identical.

## Structure
- Shared package holds:
  - `fixed_real` and `vector` typedefs.
  - FIXED_FRAC = 32.
  - FIXED_ONE = 64'h0000_0001_0000_0000.
  - FALLBACK_Z = 64'h0000_0000_8000_0000.
- Sub-module rand_sq: registered 33-bit signed squarer with a 65-bit unsigned output, instantiated three times and enabled in S_SQ.

## Test plan
- Bench drives rand_in directly. Constant 64'h0000_0000_4000_0000 (0.25) with out_ready=1 -> out_valid after edge 5; vec = three copies of 64'h0000_0000_4000_0000; fallback=0.
- Constant 33'h1_0000_0000 (-1.0), MAX_TRIES=16 -> 16 rejections, then vec=(0,0,64'h0000_0000_8000_0000) with fallback=1 at cycle 80; reject_count=16 with stats enabled.
- Triple 0.5, 0.5, 0.75 (s = 1.0625, reject) followed by 0.5, 0.5, 0.5 (s = 0.75) -> single output (0.5,0.5,0.5) after edge 10; reject_count=1.
- Accepted sample with out_ready=0 for 10 cycles while rand_in toggles -> vec and out_valid stay unchanged; raising out_ready drops out_valid after one edge.
- Reset asserted while in S_SQ -> out_valid, vec and tries go to 0 immediately; after release, a 0.25 triple yields a valid output 5 edges later.
- With stats enabled, force reject_count to 32'hFFFF_FFFE and issue 3 rejections -> reads 32'hFFFF_FFFF with no wrap.
